fetch_ctrl: RTL and testbench

- Consumer side of the stall signal produced by the hazard unit.
- Owns the PC register and the IF/ID pipeline register.
- Applies stall (hold), branch/jump redirect (flush) and bubble injection into ID/EX.
- Keeps saturating stall/flush event counters for performance debug.
- Sits between instruction memory and the decode stage of the 5-stage RV32I pipeline.

---
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller for the 5-stage RV32I pipeline.
// Owns the PC and the IF/ID register. It honours the hazard-unit stall and
// EX-stage redirects, flags ID/EX bubbles, and keeps saturating counters of
// stall cycles and redirects for performance debug.
module fetch_ctrl #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_if_id_pc;
  logic [XLEN-1:0]  r_if_id_pc4;
  logic [31:0]      r_if_id_instr;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_redirect_target;
  logic             w_stall_sat;
  logic             w_flush_sat;

  // Sequential PC increment; wraps silently at the top of the address space.
  assign w_pc_plus4        = r_pc + XLEN'(4);
  // Redirect targets are forced onto a word boundary.
  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_stall_sat       = (r_stall_cnt == '1);
  assign w_flush_sat       = (r_flush_cnt == '1);

  // A stall or a redirect squashes whatever would enter ID/EX next edge.
  assign id_ex_flush = !rst && (stall || redirect);

  // PC and IF/ID register: reset > redirect > stall (hold) > advance.
  // NOTE: all state is written with non-blocking assignments so every
  // register sees pre-edge values (e.g. if_id_pc takes the old PC).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_pc4   <= XLEN'(4);
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (redirect) begin
      // The stalled instruction in ID is wrong-path; replace it with a bubble.
      r_pc          <= w_redirect_target;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc          <= w_pc_plus4;
      r_if_id_pc    <= r_pc;
      r_if_id_pc4   <= w_pc_plus4;
      r_if_id_instr <= imem_rdata;
      r_if_id_valid <= 1'b1;
    end
  end

  // Saturating event counters; a redirect discards a simultaneous stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (redirect) begin
      if (!w_flush_sat) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (stall) begin
      if (!w_stall_sat) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_out      = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl. Two instances share the stimulus: one with
// 16-bit counters and one with 4-bit counters to reach saturation quickly.
// The stimulus process advances a behavioural fetch model and queues the
// expected post-edge state; a monitor pops and compares after every edge.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_rdata;

  logic [31:0] a_pc, a_ipc, a_ipc4, a_instr;
  logic        a_valid, a_flush;
  logic [15:0] a_scnt, a_fcnt;
  logic [31:0] b_pc, b_ipc, b_ipc4, b_instr;
  logic        b_valid, b_flush;
  logic [3:0]  b_scnt, b_fcnt;

  always #5 clk = ~clk;

  // Instruction memory: first three words are the reference program,
  // everything else is an address-derived pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_81B3;
      default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Both instances fetch the same PC sequence, so one memory serves both.
  assign imem_rdata = imem(a_pc);

  fetch_ctrl #(.CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_rdata(imem_rdata),
    .pc_out(a_pc), .if_id_pc(a_ipc), .if_id_pc4(a_ipc4),
    .if_id_instr(a_instr), .if_id_valid(a_valid), .id_ex_flush(a_flush),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  fetch_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_rdata(imem(b_pc)),
    .pc_out(b_pc), .if_id_pc(b_ipc), .if_id_pc4(b_ipc4),
    .if_id_instr(b_instr), .if_id_valid(b_valid), .id_ex_flush(b_flush),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  typedef struct {
    logic        flush;
    logic [31:0] pc, ipc, ipc4, instr;
    logic        valid;
    int unsigned scnt, fcnt;
  } exp_t;

  exp_t q[$];

  // Reference state: unbounded event counts, saturated only when compared.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid;
  int unsigned m_scnt, m_fcnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          running = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
    int unsigned lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic cycle(input bit r, input bit s, input bit j, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect = j; redirect_pc = tgt;
    e.flush = !r && (s || j);
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_instr = NOP; m_valid = 1'b0;
      m_scnt = 0; m_fcnt = 0;
    end else if (j) begin
      m_pc = tgt & ~32'h3; m_instr = NOP; m_valid = 1'b0;
      m_fcnt++;
    end else if (s) begin
      m_scnt++;
    end else begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = imem(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
    e.valid = m_valid; e.scnt = m_scnt; e.fcnt = m_fcnt;
    running = 1'b1;
    q.push_back(e);
  endtask

  // Settle just after the edge that consumes the last queued cycle.
  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  // Monitor: after every edge, pop the expected state and compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() == 0) begin
        if (running) check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        check("id_ex_flush", {31'd0, a_flush}, {31'd0, e.flush});
        check("pc_out",      a_pc,    e.pc);
        check("if_id_pc",    a_ipc,   e.ipc);
        check("if_id_pc4",   a_ipc4,  e.ipc4);
        check("if_id_instr", a_instr, e.instr);
        check("if_id_valid", {31'd0, a_valid}, {31'd0, e.valid});
        check("stall_cnt16", {16'd0, a_scnt}, sat(e.scnt, 16));
        check("flush_cnt16", {16'd0, a_fcnt}, sat(e.fcnt, 16));
        check("pc_out_w4",   b_pc,    e.pc);
        check("flush_w4",    {31'd0, b_flush}, {31'd0, e.flush});
        check("stall_cnt4",  {28'd0, b_scnt}, sat(e.scnt, 4));
        check("flush_cnt4",  {28'd0, b_fcnt}, sat(e.fcnt, 4));
      end
    end
  end

  initial begin
    // Reset, then free-run the reference program.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    after_edge();
    check("rst_pc", a_pc, 32'h0);
    check("rst_pc4", a_ipc4, 32'h4);
    check("rst_instr", a_instr, NOP);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    after_edge();
    check("run_pc", a_pc, 32'h8);
    check("run_instr", a_instr, 32'h0010_0113);

    // Two-cycle stall at pc 8.
    cycle(0, 1, 0, 0);
    #1 check("stall_flush", {31'd0, a_flush}, 32'd1);
    cycle(0, 1, 0, 0);
    after_edge();
    check("stall_pc", a_pc, 32'h8);
    check("stall_ipc", a_ipc, 32'h4);
    check("stall_cnt", {16'd0, a_scnt}, 32'd2);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    after_edge();
    check("resume_pc", a_pc, 32'h10);

    // Redirect to 0x100: two bubbles then the target.
    cycle(0, 0, 1, 32'h100);
    after_edge();
    check("redir_pc", a_pc, 32'h100);
    check("redir_valid", {31'd0, a_valid}, 32'd0);
    check("redir_fcnt", {16'd0, a_fcnt}, 32'd1);
    cycle(0, 0, 0, 0);
    after_edge();
    check("redir_ipc", a_ipc, 32'h100);
    check("redir_valid2", {31'd0, a_valid}, 32'd1);

    // Redirect with a concurrent stall, unaligned target.
    cycle(0, 1, 1, 32'h203);
    after_edge();
    check("rs_pc", a_pc, 32'h200);
    check("rs_scnt", {16'd0, a_scnt}, 32'd2);

    // Long stall saturates the narrow counter.
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    after_edge();
    check("sat_cnt4", {28'd0, b_scnt}, 32'd15);

    // Reset in the middle of a stall.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    #1 check("rst_flush", {31'd0, a_flush}, 32'd0);
    after_edge();
    check("rst_scnt", {16'd0, a_scnt}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // Back-to-back redirects and a wrap past the top of memory.
    cycle(0, 0, 1, 32'hFFFF_FFF9);
    cycle(0, 0, 1, 32'hFFFF_FFF4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r = ($urandom_range(0, 99) == 0);
      bit j = ($urandom_range(0, 4) == 0);
      bit s = ($urandom_range(0, 2) == 0);
      logic [31:0] t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
      cycle(r, s, j, t);
    end

    @(posedge clk); #3;
    running = 1'b0;
    if (q.size() != 0) check("sb_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
